cmp_sort_ctrl: RTL and testbench

- Sequencer that time-shares one 8-bit magnitude comparator (gt/lt/eq outputs) to sort a block of DEPTH unsigned bytes in ascending order.
- Bytes are loaded over a valid/ready input stream and sorted in place by bubble passes, one comparison per cycle.
- Results are drained in ascending order over a valid/ready output stream.
- Used as the ordering engine in front of downstream min/max and median consumers.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/cmp_sort_ctrl_cmp.sv | 16 +
 rtl/cmp_sort_ctrl.sv | 158 +++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator-based byte sorter.
package cmp_pkg;

  localparam int BYTE_W = 8;
  localparam logic [7:0] SWAP_SAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SORT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Saturating increment used by the swap counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SWAP_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmp_sort_ctrl_cmp.sv
// Unsigned magnitude comparator shared by every compare step of the sorter.
module cmp_sort_ctrl_cmp
  import cmp_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              gt,
  output logic              lt,
  output logic              eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Block sorter: loads DEPTH bytes, bubble-sorts them with one comparator, drains ascending.
// Optional macro CMP_SORT_EARLY_EXIT_EN ends SORT after the first pass without swaps.
module cmp_sort_ctrl
  import cmp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              busy,
  output logic [7:0]        swap_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_CMP  = IW'(DEPTH - 2);
  localparam logic [PW-1:0] LAST_PASS = PW'(DEPTH - 2);

  logic [BYTE_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_p1;
  logic [IW-1:0]     rd_idx;
  logic [PW-1:0]     pass;
  logic [7:0]        swap_cnt;
  logic [BYTE_W-1:0] cmp_a;
  logic [BYTE_W-1:0] cmp_b;
  logic              gt;
  logic              lt;
  logic              eq;
  logic              do_swap;
  logic              accept;
  logic              drain_hs;
  logic              pass_end;
  logic              sort_done;

  assign idx_p1 = idx + 1'b1;
  assign cmp_a  = mem[idx];
  assign cmp_b  = mem[idx_p1];

  cmp_sort_ctrl_cmp u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt),
    .lt (lt),
    .eq (eq)
  );

  // Only a strict greater-than swaps, so equal bytes keep their load order.
  assign do_swap  = (state == SORT) && gt && !lt && !eq;
  assign accept   = in_valid && in_ready;
  assign drain_hs = out_valid && out_ready;
  assign pass_end = (state == SORT) && (idx == LAST_CMP);

`ifdef CMP_SORT_EARLY_EXIT_EN
  logic pass_swapped;

  assign sort_done = pass_end && ((pass == LAST_PASS) || !(pass_swapped || do_swap));
`else
  assign sort_done = pass_end && (pass == LAST_PASS);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == LAST_IDX)) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        if (out_ready && (rd_idx == LAST_IDX)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Indices and swap counter; every index returns to zero when its phase ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      idx      <= '0;
      rd_idx   <= '0;
      pass     <= '0;
      swap_cnt <= '0;
    end else begin
      if (accept) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
        if (state == IDLE) swap_cnt <= '0;
      end
      if (state == SORT) begin
        if (do_swap) swap_cnt <= sat_inc(swap_cnt);
        if (pass_end) begin
          idx  <= '0;
          pass <= sort_done ? '0 : pass + 1'b1;
        end else begin
          idx <= idx_p1;
        end
      end
      if (drain_hs) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
    end
  end

`ifdef CMP_SORT_EARLY_EXIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_swapped <= 1'b0;
    end else if (state == SORT) begin
      pass_swapped <= pass_end ? 1'b0 : (pass_swapped | do_swap);
    end
  end
`endif

  // Storage has no reset; loads and swaps never coincide because they live in different states.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx] <= in_data;
    end else if (do_swap) begin
      mem[idx]    <= cmp_b;
      mem[idx_p1] <= cmp_a;
    end
  end

  assign swap_count = swap_cnt;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench for cmp_sort_ctrl: expected sorted bytes queued at load, checked at drain.
module tb_cmp_sort_ctrl;

  localparam int DEPTH = 8;
  typedef logic [7:0] blk_t [DEPTH];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic [7:0] swap_count;

  int         vectors = 0;
  int         miscompares = 0;
  int         sort_cycles = 0;
  int         sort_base = 0;
  int         exp_swaps = 0;
  int         exp_cycles = 0;
  logic [7:0] exp_q [$];

  cmp_sort_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  // SORT is the only state with busy high and out_valid low.
  always @(negedge clk) begin
    if (busy && !out_valid) sort_cycles++;
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Builds the reference results, then loads the block; returns just after a falling edge in SORT.
  task automatic applyStimulus(input blk_t vals, input bit gaps);
    blk_t       s;
    logic [7:0] t;
    int         inv;
    s = vals;
    for (int i = 0; i < DEPTH - 1; i++) begin
      for (int j = i + 1; j < DEPTH; j++) begin
        if (s[j] < s[i]) begin
          t = s[i]; s[i] = s[j]; s[j] = t;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(s[i]);
    inv = 0;
    for (int i = 0; i < DEPTH - 1; i++)
      for (int j = i + 1; j < DEPTH; j++)
        if (vals[i] > vals[j]) inv++;
    exp_swaps = (inv > 255) ? 255 : inv;
`ifdef CMP_SORT_EARLY_EXIT_EN
    begin
      blk_t c;
      bit   sw;
      c = vals;
      exp_cycles = 0;
      for (int p = 0; p < DEPTH - 1; p++) begin
        sw = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (c[i] > c[i+1]) begin
            t = c[i]; c[i] = c[i+1]; c[i+1] = t; sw = 1'b1;
          end
        end
        exp_cycles += DEPTH - 1;
        if (!sw) break;
      end
    end
`else
    exp_cycles = (DEPTH - 1) * (DEPTH - 1);
`endif
    sort_base = sort_cycles;
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1;
      in_data  = vals[k];
      checkOutput("in_ready_load", int'(in_ready), 1);
      @(negedge clk);
      if (k == 0) checkOutput("swap_clear", int'(swap_count), 0);
      if (gaps && k != DEPTH - 1) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        @(negedge clk);
      end
    end
    in_data = 8'h55;
    checkOutput("in_ready_sort", int'(in_ready), 0);
    checkOutput("busy_sort", int'(busy), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drainBlock(input int stall_at);
    int         guard;
    logic [7:0] held;
    logic [7:0] e;
    guard = 0;
    while (!out_valid && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      checkOutput("drain_timeout", 0, 1);
      exp_q.delete();
      return;
    end
    checkOutput("sort_cycles", sort_cycles - sort_base, exp_cycles);
    checkOutput("swap_count", int'(swap_count), exp_swaps);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("out_valid", int'(out_valid), 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      checkOutput("out_data", int'(out_data), int'(e));
      if (i == stall_at) begin
        held = out_data;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput("stall_valid", int'(out_valid), 1);
          checkOutput("stall_data", int'(out_data), int'(held));
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    checkOutput("out_valid_end", int'(out_valid), 0);
    checkOutput("busy_end", int'(busy), 0);
    checkOutput("in_ready_end", int'(in_ready), 1);
    checkOutput("swap_hold", int'(swap_count), exp_swaps);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    blk_t b;
    int   guard;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_swap", int'(swap_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reverse order block");
    b = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    applyStimulus(b, 1'b0);
    drainBlock(-1);

    $display("[TB] already sorted block");
    b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    applyStimulus(b, 1'b0);
    drainBlock(-1);

    $display("[TB] equal and extreme values with backpressure");
    b = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h80, 8'h01, 8'hFE};
    applyStimulus(b, 1'b0);
    drainBlock(2);

    $display("[TB] random block with input stalls");
    for (int i = 0; i < DEPTH; i++) b[i] = 8'($urandom_range(0, 255));
    applyStimulus(b, 1'b1);
    drainBlock(-1);

    $display("[TB] reset in the middle of SORT");
    b = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    applyStimulus(b, 1'b0);
    guard = 0;
    while ((sort_cycles - sort_base) < 10 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", int'(in_ready), 1);
    checkOutput("mid_rst_out_valid", int'(out_valid), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_swap", int'(swap_count), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] fresh block after reset");
    b = '{8'd30, 8'd10, 8'd20, 8'd10, 8'd255, 8'd0, 8'd99, 8'd42};
    applyStimulus(b, 1'b0);
    drainBlock(-1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
